// File: rtl/preg_alloc_ctrl.sv
// preg_alloc_ctrl
// Physical-register allocation controller for the rename stage. Grants up to
// WIDTH destination tags per cycle (all-or-nothing) from an external
// multi-port free-list FIFO. Returns commit-freed tags to that list. After a
// flush it accepts squashed tags in batches until the last batch is marked.
// It also drives the free-list reset and covers the one settling cycle after
// reset, during which the list length is stale.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   alloc_req/alloc_grant    per-slot requests, single all-slots grant
//   alloc_preg               per-slot tags (straight from fl_gotten)
//   stall, busy              rename hold, controller not in RUN
//   free_valid/free_preg     commit frees, never back-pressured
//   flush                    squash pulse (acted on only in RUN)
//   rec_valid/rec_preg       squashed tags to return during recovery
//   rec_done/rec_ready       last-batch marker / batch accepted
//   stall_cycles             saturating count of stalled cycles
//   fl_*                     free-list control (reset, skip, get, put, len)
module preg_alloc_ctrl #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int PREG_BITS = $clog2(NUM_PREGS),
  parameter int WIDTH     = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  alloc_req,
  output logic                              alloc_grant,
  output logic [WIDTH-1:0][PREG_BITS-1:0]   alloc_preg,
  output logic                              stall,
  input  logic [WIDTH-1:0]                  free_valid,
  input  logic [WIDTH-1:0][PREG_BITS-1:0]   free_preg,
  input  logic                              flush,
  input  logic [WIDTH-1:0]                  rec_valid,
  input  logic [WIDTH-1:0][PREG_BITS-1:0]   rec_preg,
  input  logic                              rec_done,
  output logic                              rec_ready,
  output logic                              busy,
  output logic [15:0]                       stall_cycles,
  output logic                              fl_rst,
  output logic [PREG_BITS:0]                fl_rst_skip,
  output logic [WIDTH-1:0]                  fl_get_en,
  input  logic [WIDTH-1:0][PREG_BITS-1:0]   fl_gotten,
  output logic [WIDTH-1:0]                  fl_put_en,
  output logic [WIDTH-1:0][PREG_BITS-1:0]   fl_put,
  input  logic [PREG_BITS:0]                fl_len
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_REC} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic [CW-1:0] n_req, n_free, n_rec;
  logic          req_fits, rec_fits;

  function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  assign n_req  = popcnt(alloc_req);
  assign n_free = popcnt(free_valid);
  assign n_rec  = popcnt(rec_valid);

  // Request count zero-extended to the length width before the compare.
  assign req_fits = (n_req != '0) &&
                    ({{(PREG_BITS + 1 - CW){1'b0}}, n_req} <= fl_len);
  // Extra bit so frees + recs cannot wrap before the lane-count compare.
  assign rec_fits = ({1'b0, n_free} + {1'b0, n_rec}) <= (CW + 1)'(WIDTH);

  assign alloc_preg  = fl_gotten;
  assign fl_rst_skip = (PREG_BITS + 1)'(NUM_AREGS);
  assign stall_cycles = rst ? cnt_q : '0;

  // State register and stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
    cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!rst) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_RUN;   // a flush here has nothing to squash
      S_RUN:   if (flush) state_d = S_REC;
      S_REC:   if (rec_done && rec_fits) state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Output logic
  always_comb begin : p_out
    logic [CW-1:0] lane;
    lane        = '0;
    fl_rst      = !rst;
    alloc_grant = 1'b0;
    fl_get_en   = '0;
    fl_put_en   = '0;
    fl_put      = '0;
    rec_ready   = 1'b0;
    stall       = 1'b1;
    busy        = 1'b1;
    if (rst) begin
      busy      = (state_q != S_RUN);
      rec_ready = (state_q == S_REC) && rec_fits;
      if (state_q == S_RUN) begin
        alloc_grant = req_fits && !flush;
        fl_get_en   = alloc_grant ? alloc_req : '0;
        stall       = (|alloc_req) && !alloc_grant;
      end
      // INIT performs no puts: the list is still settling from its reset.
      if (state_q != S_INIT) begin
        // Commit frees fill the lowest put lanes in slot order.
        for (int i = 0; i < WIDTH; i++) begin
          if (free_valid[i] && (lane < CW'(WIDTH))) begin
            fl_put_en[lane] = 1'b1;
            fl_put[lane]    = free_preg[i];
            lane            = lane + CW'(1);
          end
        end
        // Recovered tags pack directly above the frees, whole batch or none.
        if (rec_ready) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (rec_valid[i] && (lane < CW'(WIDTH))) begin
              fl_put_en[lane] = 1'b1;
              fl_put[lane]    = rec_preg[i];
              lane            = lane + CW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/preg_alloc_ctrl.md
# preg_alloc_ctrl

Physical-register allocation controller for the rename stage. It sits between the rename/dispatch slots, the commit stage and the multi-port free-list FIFO that holds free physical register tags. It grants up to WIDTH tag allocations per cycle on an all-or-nothing basis and returns freed tags from commit to the free list. After a pipeline flush it sequences recovery of squashed tags back into the list. It also owns free-list reset and the post-reset settling cycle.

## Interface
- NUM_PREGS, 64, physical registers (free-list depth)
- NUM_AREGS, 32, architectural registers; tags 0..NUM_AREGS-1 are mapped at reset
- PREG_BITS, 6, tag width, equal to $clog2(NUM_PREGS)
- WIDTH, 3, slots per cycle for alloc, free and recovery
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- alloc_req  in  1 x WIDTH  rename slot i needs a destination tag
- alloc_grant  out  1  every requesting slot is served this cycle
- alloc_preg  out  PREG_BITS x WIDTH  tag for slot i; valid only when alloc_grant and alloc_req[i]
- stall  out  1  rename must hold; equals any(alloc_req) && !alloc_grant, and is forced 1 outside RUN
- free_valid / free_preg  in  1 / PREG_BITS x WIDTH  tags released at commit; always accepted
- flush  in  1  squash pulse; enters RECOVER
- rec_valid / rec_preg  in  1 / PREG_BITS x WIDTH  squashed tags to return
- rec_done  in  1  marks the current rec batch as the last one
- rec_ready  out  1  the rec batch is accepted this cycle
- busy  out  1  state != RUN
- stall_cycles  out  16  saturating count of cycles with stall=1
- fl_rst  out  1  free-list reset, active-high
- fl_rst_skip  out  PREG_BITS+1  free-list skip count, constant NUM_AREGS
- fl_get_en  out  1 x WIDTH  free-list get enables
- fl_gotten  in  PREG_BITS x WIDTH  free-list outputs, combinational from fl_get_en
- fl_put_en / fl_put  out  1 / PREG_BITS x WIDTH  free-list put enables and data
- fl_len  in  PREG_BITS+1  free-list registered length

## Operation
- States: INIT, RUN, RECOVER. Reset state is INIT.
- While rst=0:
  - fl_rst=1.
  - fl_get_en, fl_put_en, alloc_grant, rec_ready are all 0.
  - stall=1, busy=1, stall_cycles=0.
- INIT lasts exactly 1 cycle after rst rises. The free-list fl_len is stale (reads NUM_PREGS) for that cycle, so no alloc, free or rec is performed. Next state is RUN.
- RUN:
  - n_req = popcount(alloc_req).
  - alloc_grant = (n_req != 0) && (n_req <= fl_len).
  - On grant, fl_get_en = alloc_req. Slot i gets alloc_preg[i] = fl_gotten[i], passed straight through.
  - No partial grants.
- Put-lane packing, in every non-reset state:
  - Commit frees take the lowest lanes in slot order.
  - Rec tags take the next lanes, only in RECOVER.
  - fl_put_en is a contiguous low mask.
- rec_ready = (state==RECOVER) && (popcount(free_valid) + popcount(rec_valid) <= WIDTH). Rec entries are all-or-nothing.
- flush in RUN: alloc_grant is forced 0 that cycle. Next state is RECOVER.
- RECOVER:
  - No allocation.
  - Exit to RUN the cycle after a beat with rec_done && rec_ready.
  - rec_done with rec_valid all 0 is legal and is accepted when rec_ready=1.
- flush in RECOVER is ignored.
- flush in INIT is dropped. There is nothing in flight.
- Frees are never back-pressured. Total puts never exceed NUM_PREGS - fl_len, by construction of the ISA tag count.
- Tags freed in cycle t are first grantable in t+1 (free-list put-to-get delay).
- stall_cycles increments every cycle with stall=1 and rst=1, and saturates at 65535.

## Timing
- Alloc latency is 0: grant and tags are combinational in the request cycle. Tags are consumed at the clock edge.
- Free/rec latency: fl_put_en is asserted in the same cycle as the input. The tag becomes visible to grants in the next cycle.
- State and stall_cycles are the only registers.
- Reset mid-RECOVER: return to INIT, the free list is reinitialised, and pending rec data is discarded.
- Wrap-around is handled inside the free list. The controller does no index arithmetic.
- Widths:
  - n_req, popcounts: $clog2(WIDTH+1) bits.
  - Comparisons against fl_len are zero-extended to PREG_BITS+1.

## Test plan
- Reset, then one INIT cycle with alloc_req=111 -> stall=1, no get. Next cycle: grant=1, tags 32,33,34.
- Drain to fl_len=2, then alloc_req=111 -> stall=1, fl_get_en=000, stall_cycles increments. With alloc_req=101 instead -> grant=1, tags on slots 0 and 2.
- Free tag 5 at fl_len=0 with alloc_req=001 in the same cycle -> no grant. Next cycle -> grant, alloc_preg[0]=5.
- flush, then 2 free_valid and 2 rec_valid -> rec_ready=0, fl_put_en=011. Next cycle with 0 frees -> rec_ready=1, fl_put_en=011. Then rec_done -> busy drops after 1 cycle.
- Drop rst during RECOVER -> fl_rst=1, outputs at reset values. After release -> INIT, then RUN, fl_len=32.
- Hold alloc_req=111 for 70000 cycles with an empty free list -> stall_cycles=65535.
